multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main sequencer for the multi-cycle MIPS datapath. Replaces the single-cycle opcode decoder with a Moore FSM.
//  Steps each instruction through fetch/decode/execute/memory/writeback and drives every datapath enable and mux select.
//  Stalls on a memory ready handshake, and traps on illegal opcodes or memory timeouts.
// PARAMETERS
//  MAX_WAIT  15  max consecutive mem_ready=0 cycles tolerated in a memory state before bus error (1..255)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  Op           in   6  opcode IR[31:26], sampled in DECODE
//  mem_ready    in   1  memory completes access this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if ALU Zero (beq)
//  IorD         out  1  memory address: 0=PC, 1=ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  instruction register load
//  MemtoReg     out  1  write-back data: 0=ALUOut, 1=MDR
//  RegDst       out  1  dest reg: 0=rt, 1=rd
//  RegWrite     out  1  register file write
//  ALUSrcA      out  1  ALU A: 0=PC, 1=regA
//  ALUSrcB      out  2  ALU B: 00=regB, 01=4, 10=signext imm, 11=signext imm<<2
//  ALUOp        out  2  00=add, 01=sub, 10=funct decode
//  PCSource     out  2  00=ALU result, 01=ALUOut, 10=jump target
//  instr_done   out  1  one-cycle pulse in last cycle of each retired instruction
//  trap         out  1  sticky: illegal opcode or bus error, core halted
//  bus_error    out  1  sticky: memory timeout caused the trap
//  state        out  4  current state encoding (debug)
// BEHAVIOUR
//  Encoding: RESET=0 FETCH=1 DECODE=2 MEMADR=3 MEMRD=4 MEMWB=5 MEMWR=6 EXEC=7 ALUWB=8 BRANCH=9 ADDIEX=10 ADDIWB=11 JUMP=12 TRAP=13.
//  Reset (async): state=RESET, wait_cnt=0, trap=bus_error=0. All outputs 0 in RESET. RESET->FETCH unconditionally on next edge.
//  Outputs are decoded from state only, except the gated strobes marked [r], which assert only when mem_ready=1. Unlisted outputs are 0.
//  FETCH:  MemRead=1 IorD=0 ALUSrcA=0 ALUSrcB=01 ALUOp=00 PCSource=00; IRWrite[r] PCWrite[r]; ->DECODE on mem_ready.
//  DECODE: ALUSrcA=0 ALUSrcB=11 ALUOp=00. Op 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, any other->TRAP.
//  MEMADR: ALUSrcA=1 ALUSrcB=10 ALUOp=00; ->MEMRD if lw, ->MEMWR if sw (Op latched in DECODE).
//  MEMRD:  MemRead=1 IorD=1; ->MEMWB on mem_ready.
//  MEMWB:  RegDst=0 MemtoReg=1 RegWrite=1 instr_done=1; ->FETCH.
//  MEMWR:  MemWrite=1 IorD=1; instr_done[r]; ->FETCH on mem_ready.
//  EXEC:   ALUSrcA=1 ALUSrcB=00 ALUOp=10; ->ALUWB.   ALUWB: RegDst=1 MemtoReg=0 RegWrite=1 instr_done=1; ->FETCH.
//  BRANCH: ALUSrcA=1 ALUSrcB=00 ALUOp=01 PCWriteCond=1 PCSource=01 instr_done=1; ->FETCH.
//  ADDIEX: ALUSrcA=1 ALUSrcB=10 ALUOp=00; ->ADDIWB. ADDIWB: RegDst=0 MemtoReg=0 RegWrite=1 instr_done=1; ->FETCH.
//  JUMP:   PCWrite=1 PCSource=10 instr_done=1; ->FETCH.
//  TRAP:   trap=1 and all strobes 0. Absorbing; exits only on reset.
//  Opcode is latched into an internal register on the DECODE edge; later Op changes have no effect on the current instruction.
//  Wait counter (8 bit): in FETCH/MEMRD/MEMWR it increments each cycle mem_ready=0 and clears on every state change.
//   If wait_cnt==MAX_WAIT and mem_ready=0 -> TRAP with bus_error=1. mem_ready=1 in that same cycle wins: normal advance, no error.
//  mem_ready is ignored outside FETCH/MEMRD/MEMWR.
//  Latency with zero wait (cycles FETCH..done): R=4, addi=4, lw=5, sw=4, beq=3, j=3. Each wait cycle adds 1.
//  Reset asserted mid-instruction: immediate return to RESET. No write strobe survives past the reset edge.
// TESTING
//  Reset release, mem_ready=1, Op=000000 -> state 0,1,2,7,8,1; RegWrite=1 RegDst=1 only in ALUWB; instr_done pulses once.
//  Op=100011, mem_ready=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; MemRead IorD=1 in MEMRD; MemtoReg=RegWrite=1 in MEMWB.
//  Op=101011, mem_ready low 3 cycles in MEMWR -> MemWrite held 4 cycles; instr_done only in the ready cycle; no bus_error.
//  Op=000100 then Op=000010 -> PCWriteCond=1 PCSource=01 in BRANCH; PCWrite=1 PCSource=10 in JUMP; 3 cycles each.
//  Op=111111 -> DECODE->TRAP; trap=1 and bus_error=0 held for 20 cycles; all strobes 0; rst_n pulse -> RESET->FETCH.
//  FETCH, mem_ready=0 for MAX_WAIT+1 cycles -> TRAP with bus_error=1. Repeat with ready on cycle MAX_WAIT+1 -> DECODE.
//  rst_n low during MEMWR -> async state=RESET, MemWrite=0 same cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS datapath.
// It steps each instruction through its phases, stalls on mem_ready, and traps on illegal opcodes or memory timeouts.
//
// state  | meaning
// RESET  | post-reset idle cycle, all strobes low
// FETCH  | read instruction at PC, load IR and PC+4 on ready
// DECODE | register read, branch target precompute, opcode latch
// MEMADR | effective address for lw/sw
// MEMRD  | data read from ALUOut address
// MEMWB  | load result written from MDR
// MEMWR  | data write to ALUOut address
// EXEC   | R-type ALU operation
// ALUWB  | R-type result written to rd
// BRANCH | beq compare and conditional PC load
// ADDIEX | addi ALU operation
// ADDIWB | addi result written to rt
// JUMP   | PC load from jump target
// TRAP   | halted until reset
module multicycle_control #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       trap,
    output logic       bus_error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;
    logic [5:0] r_op;
    logic       r_bus_error;
    logic       w_wait_state;
    logic       w_timeout;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // A ready in the final tolerated cycle still completes the access normally.
    assign w_timeout    = w_wait_state && !mem_ready && (r_wait_cnt == 8'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RESET;
            r_wait_cnt  <= 8'd0;
            r_op        <= 6'd0;
            r_bus_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait_cnt <= 8'd0;
            else if (w_wait_state && !mem_ready)
                r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_state == S_DECODE)
                r_op <= Op;
            if (w_timeout)
                r_bus_error <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:  w_next = S_FETCH;
            S_FETCH:  if (w_timeout) w_next = S_TRAP;
                      else if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (w_timeout) w_next = S_TRAP;
                      else if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (w_timeout) w_next = S_TRAP;
                      else if (mem_ready) w_next = S_FETCH;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_TRAP;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign trap      = (r_state == S_TRAP);
    assign bus_error = r_bus_error;
    assign state     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction is expanded into its expected cycle-by-cycle
// phase plan (state, ready, expected controls) and the DUT is compared against that plan every cycle.
module tb_multicycle_control;

    localparam int MAX_WAIT = 15;

    localparam logic [3:0] RESET = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
                           MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
                           ADDIEX = 4'd10, ADDIWB = 4'd11, JUMP = 4'd12, TRAP = 4'd13;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                           OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] Op = 6'd0;
    logic       mem_ready = 1'b1;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       instr_done, trap, bus_error;
    logic [3:0] state;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic [5:0] op;
        logic       berr;
    } step_t;

    step_t plan[$];

    multicycle_control #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .instr_done(instr_done), .trap(trap), .bus_error(bus_error),
        .state(state)
    );

    always #5 clk = ~clk;

    // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite
    // ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] instr_done trap
    logic [17:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done, trap};

    function automatic logic [17:0] exp_ctl(input logic [3:0] st, input logic rdy);
        logic pcw, pcc, iord, mr, mw, irw, m2r, rdst, rw, sa, done, tr;
        logic [1:0] sb, aop, psrc;
        {pcw, pcc, iord, mr, mw, irw, m2r, rdst, rw, sa, done, tr} = '0;
        sb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            FETCH:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
            DECODE: sb = 2'b11;
            MEMADR: begin sa = 1; sb = 2'b10; end
            MEMRD:  begin mr = 1; iord = 1; end
            MEMWB:  begin m2r = 1; rw = 1; done = 1; end
            MEMWR:  begin mw = 1; iord = 1; done = rdy; end
            EXEC:   begin sa = 1; aop = 2'b10; end
            ALUWB:  begin rdst = 1; rw = 1; done = 1; end
            BRANCH: begin sa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; done = 1; end
            ADDIEX: begin sa = 1; sb = 2'b10; end
            ADDIWB: begin rw = 1; done = 1; end
            JUMP:   begin pcw = 1; psrc = 2'b10; done = 1; end
            TRAP:   tr = 1;
            default: ;
        endcase
        return {pcw, pcc, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, aop, psrc, done, tr};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    endfunction

    // Non-memory, non-decode phases get random Op and ready: both must be ignored there.
    task automatic add(input logic [3:0] st, input logic rdy, input logic [5:0] op, input logic berr);
        step_t s;
        s.st = st; s.rdy = rdy; s.op = op; s.berr = berr;
        plan.push_back(s);
    endtask

    task automatic add_free(input logic [3:0] st, input logic berr);
        add(st, 1'($urandom), 6'($urandom), berr);
    endtask

    // Memory phase with w stall cycles; more than MAX_WAIT stalls ends in a bus-error trap.
    task automatic add_mem(input logic [3:0] st, input int w, output bit ok);
        int n;
        n = (w > MAX_WAIT) ? MAX_WAIT + 1 : w;
        for (int i = 0; i < n; i++) add(st, 1'b0, 6'($urandom), 1'b0);
        if (w > MAX_WAIT) begin
            for (int i = 0; i < 6; i++) add_free(TRAP, 1'b1);
            ok = 0;
        end else begin
            add(st, 1'b1, 6'($urandom), 1'b0);
            ok = 1;
        end
    endtask

    task automatic build(input logic [5:0] op, input int wf, input int wm);
        bit ok;
        plan.delete();
        add_mem(FETCH, wf, ok);
        if (!ok) return;
        add(DECODE, 1'($urandom), op, 1'b0);
        case (op)
            OP_LW: begin
                add_free(MEMADR, 0);
                add_mem(MEMRD, wm, ok);
                if (ok) add_free(MEMWB, 0);
            end
            OP_SW:   begin add_free(MEMADR, 0); add_mem(MEMWR, wm, ok); end
            OP_R:    begin add_free(EXEC, 0); add_free(ALUWB, 0); end
            OP_BEQ:  add_free(BRANCH, 0);
            OP_ADDI: begin add_free(ADDIEX, 0); add_free(ADDIWB, 0); end
            OP_J:    add_free(JUMP, 0);
            default: for (int i = 0; i < 20; i++) add_free(TRAP, 0);
        endcase
    endtask

    // Entered just after a rising edge; leaves just after a rising edge.
    task automatic run_plan(input int n);
        for (int i = 0; i < n && i < plan.size(); i++) begin
            Op = plan[i].op;
            mem_ready = plan[i].rdy;
            @(negedge clk);
            check("state", 32'(state), 32'(plan[i].st));
            check("ctl", 32'(obs), 32'(exp_ctl(plan[i].st, plan[i].rdy)));
            check("bus_error", 32'(bus_error), 32'(plan[i].berr));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'(RESET));
        check("rst_ctl", 32'(obs), 32'(0));
        check("rst_bus_error", 32'(bus_error), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input logic [5:0] op, input int wf, input int wm);
        build(op, wf, wm);
        run_plan(plan.size());
        if (plan[plan.size()-1].st == TRAP) apply_reset();
    endtask

    initial begin
        int r, wf, wm, len;
        logic [5:0] op;
        mem_ready = 1'b1;
        apply_reset();

        do_instr(OP_R, 0, 0);
        do_instr(OP_LW, 0, 0);
        do_instr(OP_SW, 0, 3);
        do_instr(OP_BEQ, 0, 0);
        do_instr(OP_J, 0, 0);
        do_instr(6'b111111, 0, 0);
        do_instr(OP_R, MAX_WAIT + 1, 0);
        do_instr(OP_ADDI, MAX_WAIT, 0);
        do_instr(OP_LW, MAX_WAIT, MAX_WAIT);
        do_instr(OP_SW, 1, MAX_WAIT + 1);

        // Cycle counts from FETCH to retirement with zero wait.
        build(OP_LW, 0, 0);   check("lat_lw", 32'(plan.size()), 32'd5);
        build(OP_BEQ, 0, 0);  check("lat_beq", 32'(plan.size()), 32'd3);

        // Reset asserted mid-cycle while a store is stalled.
        build(OP_SW, 0, 3);
        run_plan(4);
        mem_ready = 1'b0;
        #2;
        check("memwr_before_rst", 32'(MemWrite), 32'd1);
        check("memwr_state", 32'(state), 32'(MEMWR));
        apply_reset();
        check("memwr_after_rst", 32'(MemWrite), 32'd0);

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: op = OP_R;    1: op = OP_J;   2: op = OP_BEQ;
                3: op = OP_ADDI; 4, 5: op = OP_LW; 6, 7: op = OP_SW;
                8: op = OP_R;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            r = $urandom_range(0, 19);
            wf = (r < 15) ? $urandom_range(0, 2) : (r < 19) ? MAX_WAIT : MAX_WAIT + 1;
            r = $urandom_range(0, 19);
            wm = (r < 14) ? $urandom_range(0, 4) : (r < 18) ? MAX_WAIT : MAX_WAIT + 1 + $urandom_range(0, 2);
            do_instr(op, wf, wm);
        end

        len = n_assert;
        $display("End of test - %0d assertions evaluated, %0d failures", len, n_fail);
        $finish;
    end

endmodule
